fp_convert_mc: RTL and testbench
================================

Name: fp_convert_mc

Overview:
Multi-cycle IEEE-754 format converter between fp16 and fp32, working in the opposite direction to the datapath's dual-width FP unit. It widens fp16 operands to fp32 and narrows fp32 results to fp16, with the fp16 value zero-extended in a 32-bit word. It sits beside the FP unit in the multicycle ARM datapath and is driven by a start/done handshake from the controller. Subnormal normalisation and denormalisation are iterative, at one bit per cycle.

Parameters:
none. All widths are fixed by IEEE binary16/binary32.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
Op  in  1  0 = fp16->fp32 (source a[15:0]), 1 = fp32->fp16
a  in  32  operand, latched on accepted start
Result  out  32  converted value; narrow results are {16'b0, r16}; held until next accepted start
busy  out  1  high in CLASSIFY and SHIFT
done  out  1  single-cycle pulse; Result and Flags valid
Flags  out  3  {overflow, underflow, inexact}, valid with done, held with Result

Behaviour:
- Reset: state IDLE; Result, Flags, busy and done all 0. Reset mid-operation aborts at the next edge with no done pulse.
- States:
  - IDLE --start--> CLASSIFY.
  - CLASSIFY --(n>0)--> SHIFT, otherwise --> DONE.
  - SHIFT: counts down n; at count 1 --> DONE.
  - DONE --start--> CLASSIFY (back-to-back accepted), otherwise --> IDLE.
- Start handling: start is ignored while busy=1. a and Op are latched only on an accepted start.
- Latency: start sampled at edge 0 gives done high in cycle 2+n, where n is the shift count (0..10).
- Rounding is round-toward-zero (truncation) throughout.
- Widen (Op=0), fields s, e5, m10:
  - e=0, m=0: signed zero.
  - e=31, m=0: signed infinity.
  - e=31, m!=0: canonical NaN 0x7FC00000.
  - Normal: e8 = e5+112, m23 = m10<<13.
  - Subnormal: CLASSIFY sets n = number of left shifts needed to bring the leading 1 to bit 10 (1..10). SHIFT shifts m left one bit per cycle. Result e8 = 113-n; m23 = shifted m[9:0]<<13.
  - Widen never sets any Flags bit.
- Narrow (Op=1), fields s, e8, m23:
  - e=255, m=0: {s, 0x7C00}.
  - e=255, m!=0: 0x7E00.
  - e=0: signed zero; underflow and inexact set if m!=0.
  - e>=143: {s, 0x7BFF} (RTZ max finite); overflow and inexact set.
  - 113<=e<=142: e5 = e-112, m10 = m[22:13]; inexact = |m[12:0].
  - 103<=e<=112: n = 113-e. Load {1, m[22:13]} and shift right one bit per cycle; a sticky bit accumulates shifted-out bits plus |m[12:0]. Result exponent is 0. inexact = sticky; underflow = inexact.
  - e<=102: signed zero; underflow and inexact set.
- Sign is preserved in every case except NaN.

Decomposition:
- Shared package fp_pkg holds:
  - field widths and biases: 15, 127, difference 112
  - exponent thresholds: 143, 113, 103
  - canonical NaN constants 0x7FC00000 and 0x7E00
  - max-finite constant 0x7BFF
  - state enum: IDLE, CLASSIFY, SHIFT, DONE
- One combinational sub-module, fpcvt_classify: extracts fields, computes the case code and initial shift count n. The FSM, shifter, sticky logic and output registers stay in fp_convert_mc.

Test Plan:
- Op=0, a=0x00003C00, start → done in cycle 2, Result 0x3F800000, Flags 000; busy high only in cycle 1.
- Op=0, a=0x00000001 → n=10, done in cycle 12, Result 0x33800000, Flags 000. Op=0, a=0x00007E01 → 0x7FC00000.
- Op=1, a=0x3F800000 → 0x00003C00, Flags 000. Op=1, a=0x40490FDB → 0x00004248, Flags 001.
- Op=1, a=0x47800000 → 0x00007BFF, Flags 101. Op=1, a=0xFF800000 → 0x0000FC00, Flags 000. Op=1, a=0x7FC00001 → 0x00007E00.
- Op=1, a=0x38000000 → n=1, done in cycle 3, 0x00000200, Flags 000. Op=1, a=0x33000000 → 0x00000000, Flags 011. Op=1, a=0x80000001 → 0x00008000, Flags 011.
- Handshake checks:
  - Start Op=0, a=0x1; pulse start again in cycle 4 → ignored, single done in cycle 12.
  - Repeat, asserting reset in cycle 5 → from cycle 6 busy=0, done=0, Result=0, and no done pulse follows.
  - Start held high in the DONE cycle → new conversion accepted back-to-back.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, state and case encodings for the fp16/fp32 converter.
package fp_pkg;

  localparam logic [7:0]  F16_BIAS     = 8'd15;
  localparam logic [7:0]  F32_BIAS     = 8'd127;
  localparam logic [7:0]  BIAS_DIFF    = 8'd112;

  localparam logic [7:0]  NARROW_OVF_E  = 8'd143;
  localparam logic [7:0]  NARROW_NORM_E = 8'd113;
  localparam logic [7:0]  NARROW_SUB_E  = 8'd103;
  // fp32 exponent of a widened fp16 subnormal before subtracting the shift count
  localparam logic [7:0]  WIDEN_SUB_E   = 8'd113;

  localparam logic [31:0] NAN32  = 32'h7FC0_0000;
  localparam logic [15:0] NAN16  = 16'h7E00;
  localparam logic [15:0] MAXF16 = 16'h7BFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CASE_ZERO    = 3'd0,
    CASE_INF     = 3'd1,
    CASE_NAN     = 3'd2,
    CASE_NORMAL  = 3'd3,
    CASE_SUBNORM = 3'd4,
    CASE_OVF     = 3'd5,
    CASE_UNF     = 3'd6
  } cvt_case_e;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
  } cvt_out_t;

  // Left shifts needed to move the leading one of a nonzero fp16 fraction to bit 10.
  function automatic logic [3:0] widen_shift(input logic [9:0] m);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (m[i]) begin
        n = 4'(10 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_convert_mc_if.sv
// Controller-side handshake and data bundle for fp_convert_mc.
interface fp_convert_mc_if;
  logic        start;
  logic        Op;
  logic [31:0] a;
  logic [31:0] Result;
  logic        busy;
  logic        done;
  logic [2:0]  Flags;

  modport master (output start, Op, a, input Result, busy, done, Flags);
  modport slave  (input start, Op, a, output Result, busy, done, Flags);
endinterface

// File: rtl/fpcvt_classify.sv
// Field extraction and case decode for one conversion; also yields the
// initial shift count and the mantissa/sticky to load into the shifter.
module fpcvt_classify
  import fp_pkg::*;
(
  input  logic        op_i,
  input  logic [31:0] a_i,
  output cvt_case_e   case_o,
  output logic        sign_o,
  output logic [7:0]  exp_o,
  output logic [10:0] mant_o,
  output logic        sticky_o,
  output logic [3:0]  shift_o
);

  logic [4:0]  e5_s;
  logic [9:0]  m10_s;
  logic [7:0]  e8_s;
  logic [22:0] m23_s;
  logic [7:0]  sub_n_s;

  assign e5_s    = a_i[14:10];
  assign m10_s   = a_i[9:0];
  assign e8_s    = a_i[30:23];
  assign m23_s   = a_i[22:0];
  assign sub_n_s = NARROW_NORM_E - e8_s;

  // Decode source fields into a case and shifter load values.
  always_comb begin
    case_o   = CASE_ZERO;
    sign_o   = 1'b0;
    exp_o    = 8'd0;
    mant_o   = 11'd0;
    sticky_o = 1'b0;
    shift_o  = 4'd0;
    if (!op_i) begin
      sign_o = a_i[15];
      if (e5_s == 5'd0) begin
        if (m10_s == 10'd0) begin
          case_o = CASE_ZERO;
        end else begin
          case_o  = CASE_SUBNORM;
          shift_o = widen_shift(m10_s);
          mant_o  = {1'b0, m10_s};
        end
      end else if (e5_s == 5'd31) begin
        case_o = (m10_s == 10'd0) ? CASE_INF : CASE_NAN;
      end else begin
        case_o = CASE_NORMAL;
        exp_o  = {3'b000, e5_s} + BIAS_DIFF;
        mant_o = {1'b0, m10_s};
      end
    end else begin
      sign_o = a_i[31];
      if (e8_s == 8'd255) begin
        case_o = (m23_s == 23'd0) ? CASE_INF : CASE_NAN;
      end else if (e8_s == 8'd0) begin
        case_o = (m23_s == 23'd0) ? CASE_ZERO : CASE_UNF;
      end else if (e8_s >= NARROW_OVF_E) begin
        case_o = CASE_OVF;
      end else if (e8_s >= NARROW_NORM_E) begin
        case_o   = CASE_NORMAL;
        exp_o    = e8_s - BIAS_DIFF;
        mant_o   = {1'b0, m23_s[22:13]};
        sticky_o = |m23_s[12:0];
      end else if (e8_s >= NARROW_SUB_E) begin
        case_o   = CASE_SUBNORM;
        shift_o  = sub_n_s[3:0];
        mant_o   = {1'b1, m23_s[22:13]};
        sticky_o = |m23_s[12:0];
      end else begin
        case_o = CASE_UNF;
      end
    end
  end

endmodule

// File: rtl/fp_convert_mc.sv
// Multi-cycle fp16<->fp32 converter: start/done handshake, one-bit-per-cycle
// subnormal shifter with sticky tracking, truncating rounding.
module fp_convert_mc
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fp_convert_mc_if.slave cvt
);

  state_e      state_q, state_d;
  logic        op_q;
  logic [31:0] a_q;
  logic [10:0] mant_q, mant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  logic        accept_s, busy_s, done_s;
  cvt_case_e   cls_case_s;
  logic        cls_sign_s;
  logic [7:0]  cls_exp_s;
  logic [10:0] cls_mant_s;
  logic        cls_sticky_s;
  logic [3:0]  cls_shift_s;
  logic [10:0] shift_mant_s;
  logic        shift_sticky_s;
  cvt_out_t    fin_s;

  fpcvt_classify u_classify (
    .op_i     (op_q),
    .a_i      (a_q),
    .case_o   (cls_case_s),
    .sign_o   (cls_sign_s),
    .exp_o    (cls_exp_s),
    .mant_o   (cls_mant_s),
    .sticky_o (cls_sticky_s),
    .shift_o  (cls_shift_s)
  );

  // Pack final result word and {overflow, underflow, inexact}.
  function automatic cvt_out_t compose(input logic op, input cvt_case_e c, input logic s,
                                       input logic [7:0] e, input logic [3:0] n,
                                       input logic [10:0] m, input logic st);
    cvt_out_t   o;
    logic [7:0] sub_e;
    sub_e    = WIDEN_SUB_E - {4'h0, n};
    o.result = 32'h0000_0000;
    o.flags  = 3'b000;
    case (c)
      CASE_ZERO:    o.result = op ? {16'h0000, s, 15'h0000} : {s, 31'h0000_0000};
      CASE_INF:     o.result = op ? {16'h0000, s, 15'h7C00} : {s, 8'hFF, 23'h00_0000};
      CASE_NAN:     o.result = op ? {16'h0000, NAN16} : NAN32;
      CASE_NORMAL: begin
        o.result = op ? {16'h0000, s, e[4:0], m[9:0]} : {s, e, m[9:0], 13'h0000};
        o.flags  = op ? {2'b00, st} : 3'b000;
      end
      CASE_SUBNORM: begin
        o.result = op ? {16'h0000, s, 5'h00, m[9:0]} : {s, sub_e, m[9:0], 13'h0000};
        o.flags  = op ? {1'b0, st, st} : 3'b000;
      end
      CASE_OVF: begin
        o.result = {16'h0000, s, MAXF16[14:0]};
        o.flags  = 3'b101;
      end
      CASE_UNF: begin
        o.result = {16'h0000, s, 15'h0000};
        o.flags  = 3'b011;
      end
      default: begin
        o.result = 32'h0000_0000;
        o.flags  = 3'b000;
      end
    endcase
    return o;
  endfunction

  assign accept_s = cvt.start && ((state_q == IDLE) || (state_q == DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = accept_s ? CLASSIFY : IDLE;
      CLASSIFY: state_d = (cls_shift_s != 4'd0) ? SHIFT : DONE;
      SHIFT:    state_d = (cnt_q == 4'd1) ? DONE : SHIFT;
      DONE:     state_d = accept_s ? CLASSIFY : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy_s = (state_q == CLASSIFY) || (state_q == SHIFT);
    done_s = (state_q == DONE);
  end

  // Widen shifts left toward the hidden bit; narrow shifts right into sticky.
  assign shift_mant_s   = op_q ? {1'b0, mant_q[10:1]} : {mant_q[9:0], 1'b0};
  assign shift_sticky_s = sticky_q | (op_q & mant_q[0]);

  // Shifter load/step and final result capture.
  always_comb begin
    mant_d   = mant_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    result_d = result_q;
    flags_d  = flags_q;
    fin_s    = '0;
    if (state_q == CLASSIFY) begin
      mant_d   = cls_mant_s;
      cnt_d    = cls_shift_s;
      sticky_d = cls_sticky_s;
      fin_s    = compose(op_q, cls_case_s, cls_sign_s, cls_exp_s, cls_shift_s,
                         cls_mant_s, cls_sticky_s);
      if (cls_shift_s == 4'd0) begin
        result_d = fin_s.result;
        flags_d  = fin_s.flags;
      end else begin
        result_d = result_q;
        flags_d  = flags_q;
      end
    end else if (state_q == SHIFT) begin
      mant_d   = shift_mant_s;
      cnt_d    = cnt_q - 4'd1;
      sticky_d = shift_sticky_s;
      fin_s    = compose(op_q, cls_case_s, cls_sign_s, cls_exp_s, cls_shift_s,
                         shift_mant_s, shift_sticky_s);
      if (cnt_q == 4'd1) begin
        result_d = fin_s.result;
        flags_d  = fin_s.flags;
      end else begin
        result_d = result_q;
        flags_d  = flags_q;
      end
    end else begin
      mant_d   = mant_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
    end
  end

  // Operand latch and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= 1'b0;
      a_q      <= 32'h0000_0000;
      mant_q   <= 11'd0;
      cnt_q    <= 4'd0;
      sticky_q <= 1'b0;
      result_q <= 32'h0000_0000;
      flags_q  <= 3'b000;
    end else begin
      if (accept_s) begin
        op_q <= cvt.Op;
        a_q  <= cvt.a;
      end
      mant_q   <= mant_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign cvt.Result = result_q;
  assign cvt.Flags  = flags_q;
  assign cvt.busy   = busy_s;
  assign cvt.done   = done_s;

endmodule

// File: tb/tb_fp_convert_mc.sv
// Directed-vector bench for fp_convert_mc with hand-computed expectations.
module tb_fp_convert_mc;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;

  fp_convert_mc_if cvt();

  fp_convert_mc dut (
    .clk   (clk),
    .reset (reset),
    .cvt   (cvt.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start one conversion and check latency, busy, result, flags and done width.
  task automatic convert(input string tag, input logic op, input logic [31:0] a,
                         input int lat, input logic [31:0] res, input logic [2:0] fl);
    int   cyc;
    logic seen;
    @(negedge clk);
    cvt.start = 1'b1;
    cvt.Op    = op;
    cvt.a     = a;
    @(posedge clk);
    #1;
    cvt.start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "/busy1"}, {31'h0, cvt.busy}, 32'h1);
      if (cvt.done) seen = 1'b1;
    end
    check({tag, "/lat"}, 32'(cyc), 32'(lat));
    check({tag, "/res"}, cvt.Result, res);
    check({tag, "/flg"}, {29'h0, cvt.Flags}, {29'h0, fl});
    check({tag, "/busy_done"}, {31'h0, cvt.busy}, 32'h0);
    @(negedge clk);
    check({tag, "/pulse"}, {31'h0, cvt.done}, 32'h0);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    reset     = 1'b1;
    cvt.start = 1'b0;
    cvt.Op    = 1'b0;
    cvt.a     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", {31'h0, cvt.busy}, 32'h0);
    check("rst/done", {31'h0, cvt.done}, 32'h0);
    check("rst/res", cvt.Result, 32'h0);
    check("rst/flg", {29'h0, cvt.Flags}, 32'h0);
    reset = 1'b0;

    convert("w_one",    1'b0, 32'h0000_3C00,  2, 32'h3F80_0000, 3'b000);
    convert("w_sub1",   1'b0, 32'h0000_0001, 12, 32'h3380_0000, 3'b000);
    convert("w_nan",    1'b0, 32'h0000_7E01,  2, 32'h7FC0_0000, 3'b000);
    convert("w_nsub",   1'b0, 32'h0000_8200,  3, 32'hB800_0000, 3'b000);
    convert("w_inf",    1'b0, 32'h0000_7C00,  2, 32'h7F80_0000, 3'b000);
    convert("w_nzero",  1'b0, 32'h0000_8000,  2, 32'h8000_0000, 3'b000);
    convert("n_one",    1'b1, 32'h3F80_0000,  2, 32'h0000_3C00, 3'b000);
    convert("n_pi",     1'b1, 32'h4049_0FDB,  2, 32'h0000_4248, 3'b001);
    convert("n_ovf",    1'b1, 32'h4780_0000,  2, 32'h0000_7BFF, 3'b101);
    convert("n_ninf",   1'b1, 32'hFF80_0000,  2, 32'h0000_FC00, 3'b000);
    convert("n_nan",    1'b1, 32'h7FC0_0001,  2, 32'h0000_7E00, 3'b000);
    convert("n_sub1",   1'b1, 32'h3800_0000,  3, 32'h0000_0200, 3'b000);
    convert("n_tiny",   1'b1, 32'h3300_0000,  2, 32'h0000_0000, 3'b011);
    convert("n_ndenrm", 1'b1, 32'h8000_0001,  2, 32'h0000_8000, 3'b011);
    convert("n_sub2st", 1'b1, 32'h3780_0001,  4, 32'h0000_0100, 3'b011);
    convert("n_sub3sh", 1'b1, 32'h3700_6000,  5, 32'h0000_0080, 3'b011);

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    cvt.start = 1'b1;
    cvt.Op    = 1'b0;
    cvt.a     = 32'h0000_0001;
    @(posedge clk);
    #1;
    cvt.start  = 1'b0;
    done_cnt   = 0;
    first_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        cvt.start = 1'b1;
        cvt.a     = 32'h0000_3C00;
      end
      if (c == 4) cvt.start = 1'b0;
      if (cvt.done) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
    end
    check("ign/count", 32'(done_cnt), 32'd1);
    check("ign/cycle", 32'(first_done), 32'd12);
    check("ign/res", cvt.Result, 32'h3380_0000);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    cvt.start = 1'b1;
    cvt.Op    = 1'b0;
    cvt.a     = 32'h0000_0001;
    @(posedge clk);
    #1;
    cvt.start = 1'b0;
    done_cnt  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (cvt.done) done_cnt++;
      if (c == 5) reset = 1'b1;
      if (c == 6) begin
        check("abort/busy", {31'h0, cvt.busy}, 32'h0);
        check("abort/done", {31'h0, cvt.done}, 32'h0);
        check("abort/res", cvt.Result, 32'h0);
        reset = 1'b0;
      end
    end
    check("abort/nodone", 32'(done_cnt), 32'd0);

    // Start held through DONE starts the next conversion back-to-back.
    @(negedge clk);
    cvt.start = 1'b1;
    cvt.Op    = 1'b1;
    cvt.a     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    cvt.a = 32'h4049_0FDB;
    @(negedge clk);
    @(negedge clk);
    check("b2b/done1", {31'h0, cvt.done}, 32'h1);
    check("b2b/res1", cvt.Result, 32'h0000_3C00);
    @(negedge clk);
    check("b2b/busy", {31'h0, cvt.busy}, 32'h1);
    cvt.start = 1'b0;
    @(negedge clk);
    check("b2b/done2", {31'h0, cvt.done}, 32'h1);
    check("b2b/res2", cvt.Result, 32'h0000_4248);
    check("b2b/flg2", {29'h0, cvt.Flags}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
